if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Next-generation instruction-fetch stage: owns the PC and issues in-order requests to instruction memory over a valid/ready port.
- Buffers returning instructions with their PCs in a FQ_DEPTH-entry fetch queue, and presents them to decode over valid/ready.
- Supports multiple outstanding requests, branch-prediction redirect and pipeline flush; stale responses for flushed requests are discarded.
- Sits between the BPU/EX redirect logic and the IF/ID boundary.

Parameters:
- WIDTH, 32: PC and instruction width in bits.
- FQ_DEPTH, 4: fetch queue entries, which is also the maximum number of outstanding requests. Power of two, at least 2.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-high.
- flush_in  in  1  redirect from EX; discards all queued and in-flight fetches.
- pc_branch_in  in  WIDTH  redirect target, valid while flush_in is high.
- prediction_in  in  1  BPU predicts taken for the current imem_addr_out.
- pc_prediction_in  in  WIDTH  predicted target for imem_addr_out.
- imem_req_valid_out  out  1  fetch request valid.
- imem_req_ready_in  in  1  memory accepts the request.
- imem_addr_out  out  WIDTH  fetch address, equal to the current PC.
- imem_rsp_valid_in  in  1  instruction returned; responses are in order and cannot be stalled.
- imem_rsp_data_in  in  WIDTH  returned instruction word.
- inst_valid_out  out  1  head entry filled and presented to decode.
- inst_ready_in  in  1  decode accepts; deasserted when decode stalls.
- inst_out  out  WIDTH  head instruction.
- pc_out  out  WIDTH  PC of the head instruction.

Behaviour:
- Reset values: pc = RESET_PC; queue empty (count 0, head/tail 0, all filled bits 0); drop_cnt 0; imem_req_valid_out 0; inst_valid_out 0; inst_out and pc_out 0.
- Reset mid-operation clears everything immediately. The memory shares the same reset, so no stale responses survive it.
- Credit: imem_req_valid_out = !flush_in && (count + drop_cnt < FQ_DEPTH). imem_addr_out = pc.
- Request handshake (valid && ready):
  - allocate the tail entry with {pc, filled = 0};
  - tail++ modulo FQ_DEPTH, count++;
  - pc <= prediction_in ? pc_prediction_in : pc + 4, with addition modulo 2^WIDTH so 32'hFFFF_FFFC wraps to 0.
- No handshake: pc holds.
- Response, in order:
  - If drop_cnt > 0: drop_cnt--, data discarded.
  - Otherwise write data into the oldest unfilled entry (fill pointer) and set its filled bit.
  - Response with no outstanding request is a protocol violation: assertion fires and the response is ignored.
- Dequeue: inst_valid_out = (count > 0) && head.filled. On inst_valid_out && inst_ready_in: head++, count--.
- Latency: first request in the cycle after reset release. With a 1-cycle memory, an instruction is visible at inst_valid_out 1 cycle after its response; the queue output is registered from storage with no combinational path from imem_rsp_* to inst_*.
- Throughput: 1 instruction/cycle when memory and decode are always ready.
- Flush (has priority over every other event in that cycle):
  - pc <= pc_branch_in;
  - count, head, tail and fill pointer reset to empty;
  - any dequeue or request handshake in that cycle is void (request valid is already forced low);
  - drop_cnt <= drop_cnt + unfilled_entries - (rsp_valid ? 1 : 0). The response in the flush cycle is consumed against the old state and discarded.
- Post-flush: new requests issue immediately, bounded by the credit rule. Because responses are in order, all dropped responses arrive before any new ones.
- Full: count + drop_cnt == FQ_DEPTH deasserts imem_req_valid_out. A same-cycle dequeue does not open credit until the next cycle; credit is a registered-state check.
- Counters are $clog2(FQ_DEPTH+1) bits wide and never exceed FQ_DEPTH.

Decomposition:
- Package if_pkg:
  - typedef fq_entry_t {pc, inst, filled};
  - localparam FQ_PTR_W = $clog2(FQ_DEPTH);
  - constant PC_INC = 4;
  - RESET_PC default.
- Sub-module fetch_queue: circular buffer with alloc, fill and pop ports; head/tail/fill pointers; count.
- if_fetch_unit holds the PC, credit logic and drop counter.

Test Plan:
- Reset release, memory and decode always ready, 1-cycle latency → requests to 0x0, 0x4, 0x8…; decode receives (pc, inst) in order at 1/cycle.
- inst_ready_in held low, FQ_DEPTH = 4 → exactly 4 requests issued (0x0–0xC), then imem_req_valid_out = 0. Releasing ready resumes with 0x10 one cycle after the first dequeue.
- prediction_in = 1 with pc_prediction_in = 0x100 on the request for 0x8 → next request address is 0x100; queue holds 0x0, 0x4, 0x8, 0x100.
- 3 requests outstanding (memory latency 4), then flush_in with pc_branch_in = 0x200 → the next request is 0x200, 3 responses are dropped, and the first inst_out delivered has pc_out = 0x200.
- Flush in the same cycle as a response, with 2 unfilled entries → drop_cnt = 1; only the next response is discarded.
- Assert rst_in mid-stream with a full queue → all outputs return to reset values in the same cycle (asynchronous); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared constants for the instruction-fetch stage: default geometry,
// reset PC and the sequential PC increment.
package if_pkg;

    localparam int unsigned WIDTH_DEF    = 32;
    localparam int unsigned FQ_DEPTH_DEF = 4;
    localparam int unsigned FQ_PTR_W     = $clog2(FQ_DEPTH_DEF);
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned PC_INC       = 4;

    // One fetch-queue slot at the default width; fetch_queue declares the same
    // shape locally so that WIDTH stays a true parameter.
    typedef struct packed {
        logic [WIDTH_DEF-1:0] pc;
        logic [WIDTH_DEF-1:0] inst;
        logic                 filled;
    } fq_entry_t;

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// Circular fetch queue: entries are allocated at request time, filled in order
// as responses return, and popped from the head once filled.
module fetch_queue #(
    parameter  int unsigned WIDTH    = 32,
    parameter  int unsigned FQ_DEPTH = 4,
    localparam int unsigned PTR_W    = $clog2(FQ_DEPTH),
    localparam int unsigned CNT_W    = $clog2(FQ_DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             alloc_i,
    input  logic [WIDTH-1:0] alloc_pc_i,
    input  logic             fill_i,
    input  logic [WIDTH-1:0] fill_data_i,
    input  logic             pop_i,
    output logic             head_valid_o,
    output logic [WIDTH-1:0] head_pc_o,
    output logic [WIDTH-1:0] head_inst_o,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] unfilled_o
);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] inst;
        logic             filled;
    } fq_slot_t;

    fq_slot_t         slot_q [FQ_DEPTH];
    logic [PTR_W-1:0] head_q, tail_q, fill_q;
    logic [CNT_W-1:0] count_q, unfilled_q;

    // NOTE: storage is reset as well, because the head slot drives inst/pc
    // outputs directly and those must read zero out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FQ_DEPTH; i++) slot_q[i] <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            unfilled_q <= '0;
        end else if (flush_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            unfilled_q <= '0;
        end else begin
            // NOTE: non-blocking updates let alloc, fill and pop all read the
            // pre-edge pointers even when they land in the same cycle.
            if (alloc_i) begin
                slot_q[tail_q] <= '{pc: alloc_pc_i, inst: '0, filled: 1'b0};
                tail_q         <= tail_q + PTR_W'(1);
            end
            if (fill_i) begin
                slot_q[fill_q].inst   <= fill_data_i;
                slot_q[fill_q].filled <= 1'b1;
                fill_q                <= fill_q + PTR_W'(1);
            end
            if (pop_i) head_q <= head_q + PTR_W'(1);
            count_q    <= count_q + CNT_W'(alloc_i) - CNT_W'(pop_i);
            unfilled_q <= unfilled_q + CNT_W'(alloc_i) - CNT_W'(fill_i);
        end
    end

    assign head_valid_o = (count_q != '0) && slot_q[head_q].filled;
    assign head_pc_o    = slot_q[head_q].pc;
    assign head_inst_o  = slot_q[head_q].inst;
    assign count_o      = count_q;
    assign unfilled_o   = unfilled_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited requests to
// instruction memory and discards responses belonging to flushed requests.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter  int unsigned      WIDTH    = WIDTH_DEF,
    parameter  int unsigned      FQ_DEPTH = FQ_DEPTH_DEF,
    parameter  logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
    localparam int unsigned      CNT_W    = $clog2(FQ_DEPTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush_in,
    input  logic [WIDTH-1:0] pc_branch_in,
    input  logic             prediction_in,
    input  logic [WIDTH-1:0] pc_prediction_in,
    output logic             imem_req_valid_out,
    input  logic             imem_req_ready_in,
    output logic [WIDTH-1:0] imem_addr_out,
    input  logic             imem_rsp_valid_in,
    input  logic [WIDTH-1:0] imem_rsp_data_in,
    output logic             inst_valid_out,
    input  logic             inst_ready_in,
    output logic [WIDTH-1:0] inst_out,
    output logic [WIDTH-1:0] pc_out
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] count, unfilled;
    logic [CNT_W:0]   occupancy;
    logic             req_hs, rsp_drop, rsp_fill, pop;

    // Credit counts both live entries and requests still owed a stale response.
    assign occupancy          = {1'b0, count} + {1'b0, drop_cnt_q};
    assign imem_req_valid_out = !rst_in && !flush_in && (occupancy < (CNT_W + 1)'(FQ_DEPTH));
    assign imem_addr_out      = pc_q;
    assign req_hs             = imem_req_valid_out && imem_req_ready_in;
    assign rsp_drop           = imem_rsp_valid_in && (drop_cnt_q != '0);
    assign rsp_fill           = imem_rsp_valid_in && (drop_cnt_q == '0) && (unfilled != '0);
    assign pop                = inst_valid_out && inst_ready_in;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        if (flush_in) begin
            pc_d       = pc_branch_in;
            drop_cnt_d = drop_cnt_q + unfilled - CNT_W'(rsp_drop || rsp_fill);
        end else begin
            if (req_hs) pc_d = prediction_in ? pc_prediction_in : pc_q + WIDTH'(PC_INC);
            if (rsp_drop) drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_queue #(
        .WIDTH    (WIDTH),
        .FQ_DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk_i        (clk_in),
        .rst_i        (rst_in),
        .flush_i      (flush_in),
        .alloc_i      (req_hs),
        .alloc_pc_i   (pc_q),
        .fill_i       (rsp_fill),
        .fill_data_i  (imem_rsp_data_in),
        .pop_i        (pop),
        .head_valid_o (inst_valid_out),
        .head_pc_o    (pc_out),
        .head_inst_o  (inst_out),
        .count_o      (count),
        .unfilled_o   (unfilled)
    );

    // A response must belong either to a dropped request or to an unfilled entry.
    rsp_has_owner: assert property (@(posedge clk_in) disable iff (rst_in)
        imem_rsp_valid_in |-> (rsp_drop || rsp_fill));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: an in-order memory with configurable
// latency plus an epoch-tagged reference model of the fetch stream.
module tb_if_fetch_unit;

    localparam int          D      = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        flush_in, prediction_in, imem_req_ready_in, imem_rsp_valid_in, inst_ready_in;
    logic [31:0] pc_branch_in, pc_prediction_in, imem_rsp_data_in;
    logic        imem_req_valid_out, inst_valid_out;
    logic [31:0] imem_addr_out, inst_out, pc_out;

    if_fetch_unit #(.WIDTH(32), .FQ_DEPTH(D), .RESET_PC(RST_PC)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .flush_in           (flush_in),
        .pc_branch_in       (pc_branch_in),
        .prediction_in      (prediction_in),
        .pc_prediction_in   (pc_prediction_in),
        .imem_req_valid_out (imem_req_valid_out),
        .imem_req_ready_in  (imem_req_ready_in),
        .imem_addr_out      (imem_addr_out),
        .imem_rsp_valid_in  (imem_rsp_valid_in),
        .imem_rsp_data_in   (imem_rsp_data_in),
        .inst_valid_out     (inst_valid_out),
        .inst_ready_in      (inst_ready_in),
        .inst_out           (inst_out),
        .pc_out             (pc_out)
    );

    always #5 clk_in = ~clk_in;

    // Fetched stream of the current epoch, oldest first, as decode should see it.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          filled;
    } ent_t;
    // A request sitting inside the memory, tagged with the epoch that issued it.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          epoch;
        int          due;
    } mreq_t;

    ent_t        cur_q[$];
    mreq_t       mem_q[$];
    int          epoch = 0;
    logic [31:0] pc_m;
    int          cyc = 0;
    int          last_due = 0;
    int          lat = 1;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF8;
        t[1:0] = 2'b00;
        return t;
    endfunction

    task automatic model_reset();
        cur_q.delete();
        mem_q.delete();
        epoch++;
        pc_m     = RST_PC;
        last_due = cyc;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"},  32'(imem_req_valid_out), 32'd0);
        check({tag, "_inst_valid"}, 32'(inst_valid_out),     32'd0);
        check({tag, "_addr"},       imem_addr_out,           RST_PC);
        check({tag, "_inst"},       inst_out,                32'd0);
        check({tag, "_pc"},         pc_out,                  32'd0);
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic step(input bit f, input logic [31:0] br, input bit p,
                        input logic [31:0] ppc, input bit rr, input bit dr);
        bit    rsp, exp_rv, exp_iv;
        int    stale, due;
        mreq_t r;
        flush_in          = f;
        pc_branch_in      = br;
        prediction_in     = p;
        pc_prediction_in  = ppc;
        imem_req_ready_in = rr;
        inst_ready_in     = dr;
        rsp               = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid_in = rsp;
        imem_rsp_data_in  = rsp ? mem_q[0].data : $urandom;
        stale = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
        exp_rv = !f && (stale + cur_q.size() < D);
        exp_iv = (cur_q.size() > 0) && cur_q[0].filled;
        #1;
        check("req_valid",  32'(imem_req_valid_out), 32'(exp_rv));
        check("imem_addr",  imem_addr_out,           pc_m);
        check("inst_valid", 32'(inst_valid_out),     32'(exp_iv));
        if (exp_iv) begin
            check("inst_out", inst_out, cur_q[0].inst);
            check("pc_out",   pc_out,   cur_q[0].pc);
        end
        if (rsp) begin
            r = mem_q.pop_front();
            if (r.epoch == epoch) begin
                for (int i = 0; i < cur_q.size(); i++) begin
                    if (!cur_q[i].filled) begin
                        cur_q[i].filled = 1'b1;
                        cur_q[i].inst   = r.data;
                        break;
                    end
                end
            end
        end
        if (f) begin
            epoch++;
            cur_q.delete();
            pc_m = br;
        end else begin
            if (exp_iv && dr) void'(cur_q.pop_front());
            if (exp_rv && rr) begin
                cur_q.push_back('{pc: pc_m, inst: 32'd0, filled: 1'b0});
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                mem_q.push_back('{addr: pc_m, data: $urandom, epoch: epoch, due: due});
                last_due = due;
                pc_m = p ? ppc : pc_m + 32'd4;
            end
        end
        @(posedge clk_in);
        cyc++;
        @(negedge clk_in);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic mid_reset();
        #2;
        flush_in          = 1'b0;
        imem_rsp_valid_in = 1'b0;
        rst_in            = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    initial begin
        int pr, pf, prr, pdr, n;
        rst_in = 1'b1;
        {flush_in, prediction_in, imem_req_ready_in, imem_rsp_valid_in, inst_ready_in} = '0;
        pc_branch_in = '0; pc_prediction_in = '0; imem_rsp_data_in = '0;
        model_reset();
        repeat (3) @(negedge clk_in);
        check_reset_outputs("reset");
        rst_in = 1'b0;

        // Streaming at one instruction per cycle with a 1-cycle memory.
        lat = 1;
        repeat (30) step(0, 0, 0, 0, 1, 1);

        // Decode stalled: credit exhausts after FQ_DEPTH requests, then resumes.
        mid_reset();
        repeat (10) step(0, 0, 0, 0, 1, 0);
        repeat (12) step(0, 0, 0, 0, 1, 1);

        // Predicted-taken redirect on the request for 0x8.
        mid_reset();
        repeat (8) step(0, 0, (pc_m == 32'h8), 32'h100, 1, 0);
        repeat (10) step(0, 0, 0, 0, 1, 1);

        // Three requests in flight with latency 4, then a flush to 0x200.
        mid_reset();
        lat = 4;
        repeat (3) step(0, 0, 0, 0, 1, 1);
        step(1, 32'h200, 0, 0, 1, 1);
        repeat (20) step(0, 0, 0, 0, 1, 1);

        // Flush landing on a response cycle with two entries still unfilled.
        mid_reset();
        lat = 2;
        repeat (4) step(0, 0, 0, 0, 1, 0);
        step(1, 32'h300, 0, 0, 1, 0);
        repeat (12) step(0, 0, 0, 0, 1, 1);

        // PC wraps past the top of the address space.
        step(1, 32'hFFFF_FFF8, 0, 0, 1, 1);
        repeat (12) step(0, 0, 0, 0, 1, 1);

        // Random phases with varying latency, back-pressure, flushes and predictions.
        for (int ph = 0; ph < 40; ph++) begin
            lat = $urandom_range(1, 5);
            prr = $urandom_range(40, 100);
            pdr = $urandom_range(20, 100);
            pf  = $urandom_range(0, 12);
            pr  = $urandom_range(0, 30);
            n   = $urandom_range(40, 80);
            for (int c = 0; c < n; c++) begin
                step($urandom_range(0, 99) < pf, rand_target(),
                     $urandom_range(0, 99) < pr, rand_target(),
                     $urandom_range(0, 99) < prr, $urandom_range(0, 99) < pdr);
            end
            if (ph % 7 == 3) begin
                repeat (8) step(0, 0, 0, 0, 1, 0);
                mid_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
